// File: rtl/reg12_arbiter.sv
// reg12_arbiter: round-robin arbiter/sequencer sharing one 12-bit user register.
// Ports: CLK, RST_N (sync, active-low); REQ/OP/DATA per requester; REG_Q register value;
//   GNT/ACK per requester; RDATA/FLAG result; REG_LOAD/INC/DEC/CLR strobes + REG_DIN.
module reg12_arbiter #(
    parameter int NREQ = 3,
    parameter bit SAT  = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NREQ-1:0]      REQ,
    input  logic [2*NREQ-1:0]    OP,
    input  logic [12*NREQ-1:0]   DATA,
    input  logic [11:0]          REG_Q,
    output logic [NREQ-1:0]      GNT,
    output logic [NREQ-1:0]      ACK,
    output logic [11:0]          RDATA,
    output logic                 FLAG,
    output logic                 REG_LOAD,
    output logic                 REG_INC,
    output logic                 REG_DEC,
    output logic                 REG_CLR,
    output logic [11:0]          REG_DIN
);

    localparam int PW = $clog2(NREQ);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     win_q, win_d;
    logic [1:0]        op_q, op_d;
    logic [11:0]       data_q, data_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [11:0]       rdata_q, rdata_d;
    logic              flag_q, flag_d;
    logic              lim_q, lim_d;
    logic              ld_q, ld_d;
    logic              inc_q, inc_d;
    logic              dec_q, dec_d;
    logic              clr_q, clr_d;
    logic [11:0]       din_q, din_d;

    logic [1:0]        op_a   [NREQ];
    logic [11:0]       data_a [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign op_a[g]   = OP[2*g +: 2];
        assign data_a[g] = DATA[12*g +: 12];
    end

    // Round-robin search: first requester at or after ptr_q, wrapping.
    logic              found;
    logic [PW-1:0]     pick;
    logic [PW:0]       sum;
    logic [PW-1:0]     cand;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            cand = sum[PW-1:0];
            if (!found && REQ[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    logic lim;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        op_d    = op_q;
        data_d  = data_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        flag_d  = 1'b0;
        lim_d   = lim_q;
        ld_d    = 1'b0;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        clr_d   = 1'b0;
        din_d   = '0;
        lim     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    win_d   = pick;
                    op_d    = op_a[pick];
                    data_d  = data_a[pick];
                    gnt_d   = NREQ'(1) << pick;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // REG_Q still holds the pre-operation value here.
                lim = ((op_q == OP_INC) && (REG_Q == 12'hFFF)) ||
                      ((op_q == OP_DEC) && (REG_Q == 12'h000));
                lim_d = lim;
                if (!(SAT && lim)) begin
                    unique case (op_q)
                        OP_LOAD: ld_d  = 1'b1;
                        OP_INC:  inc_d = 1'b1;
                        OP_DEC:  dec_d = 1'b1;
                        OP_CLR:  clr_d = 1'b1;
                        default: ;
                    endcase
                end
                din_d   = (op_q == OP_LOAD) ? data_q : 12'h000;
                state_d = S_RESP;
            end
            S_RESP: begin
                // Strobes were high this cycle; the negedge update is visible now.
                rdata_d = REG_Q;
                ack_d   = NREQ'(1) << win_q;
                flag_d  = lim_q;
                ptr_d   = (win_q == PW'(NREQ-1)) ? '0 : win_q + 1'b1;
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            op_q    <= OP_LOAD;
            data_q  <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            flag_q  <= 1'b0;
            lim_q   <= 1'b0;
            ld_q    <= 1'b0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            clr_q   <= 1'b0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            op_q    <= op_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            flag_q  <= flag_d;
            lim_q   <= lim_d;
            ld_q    <= ld_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            clr_q   <= clr_d;
            din_q   <= din_d;
        end
    end

    assign GNT      = gnt_q;
    assign ACK      = ack_q;
    assign RDATA    = rdata_q;
    assign FLAG     = flag_q;
    assign REG_LOAD = ld_q;
    assign REG_INC  = inc_q;
    assign REG_DEC  = dec_q;
    assign REG_CLR  = clr_q;
    assign REG_DIN  = din_q;

endmodule

// File: tb/tb_reg12_arbiter.sv
// tb_reg12_arbiter: wrap (SAT=0) and saturating (SAT=1) arbiters on shared
// stimulus, each with its own negedge register and a transaction-level model.
module tb_reg12_arbiter;

    localparam int N    = 3;
    localparam int MAXC = 4096;

    localparam logic [1:0] LD  = 2'b00;
    localparam logic [1:0] INC = 2'b01;
    localparam logic [1:0] DEC = 2'b10;
    localparam logic [1:0] CLR = 2'b11;

    logic            CLK   = 1'b0;
    logic            RST_N = 1'b0;
    logic [N-1:0]    REQ   = '0;
    logic [2*N-1:0]  OP    = '0;
    logic [12*N-1:0] DATA  = '0;

    logic [N-1:0]    gnt   [2];
    logic [N-1:0]    ack   [2];
    logic [11:0]     rdata [2];
    logic [11:0]     din   [2];
    logic [11:0]     rq    [2] = '{12'h000, 12'h000};
    logic [1:0]      flag, ld, inc, dec, clr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ld_cnt  [2] = '{0, 0};
    int inc_cnt [2] = '{0, 0};
    int dec_cnt [2] = '{0, 0};

    always #5 CLK = ~CLK;

    reg12_arbiter #(.NREQ(N), .SAT(1'b0)) u_wrap (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .OP(OP), .DATA(DATA),
        .REG_Q(rq[0]), .GNT(gnt[0]), .ACK(ack[0]), .RDATA(rdata[0]),
        .FLAG(flag[0]), .REG_LOAD(ld[0]), .REG_INC(inc[0]),
        .REG_DEC(dec[0]), .REG_CLR(clr[0]), .REG_DIN(din[0])
    );

    reg12_arbiter #(.NREQ(N), .SAT(1'b1)) u_sat (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .OP(OP), .DATA(DATA),
        .REG_Q(rq[1]), .GNT(gnt[1]), .ACK(ack[1]), .RDATA(rdata[1]),
        .FLAG(flag[1]), .REG_LOAD(ld[1]), .REG_INC(inc[1]),
        .REG_DEC(dec[1]), .REG_CLR(clr[1]), .REG_DIN(din[1])
    );

    // The shared register itself: updates on the falling edge, never reset.
    always @(negedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            if (ld[k])       rq[k] <= din[k];
            else if (inc[k]) rq[k] <= rq[k] + 12'd1;
            else if (dec[k]) rq[k] <= rq[k] - 12'd1;
            else if (clr[k]) rq[k] <= 12'h000;
            if (ld[k])  ld_cnt[k]  <= ld_cnt[k] + 1;
            if (inc[k]) inc_cnt[k] <= inc_cnt[k] + 1;
            if (dec[k]) dec_cnt[k] <= dec_cnt[k] + 1;
        end
    end

    task automatic chk(input string nm, input int k, input int c,
                       input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d: got %0h want %0h", nm, k, c, a, e);
        end
    endtask

    // Result of one operation on a register value, from the opcode rules.
    function automatic void apply(input logic [1:0] op, input logic [11:0] d,
                                  input logic [11:0] cur, input bit sat,
                                  output logic [11:0] nv, output bit lim,
                                  output bit [3:0] stb);
        lim = 1'b0;
        stb = 4'b0000;
        nv  = cur;
        case (op)
            LD: begin
                nv  = d;
                stb = 4'b0001;
            end
            INC: begin
                lim = (cur == 12'hFFF);
                if (!(sat && lim)) begin
                    nv  = cur + 12'd1;
                    stb = 4'b0010;
                end
            end
            DEC: begin
                lim = (cur == 12'h000);
                if (!(sat && lim)) begin
                    nv  = cur - 12'd1;
                    stb = 4'b0100;
                end
            end
            default: begin
                nv  = 12'h000;
                stb = 4'b1000;
            end
        endcase
    endfunction

    // Expected outputs after each posedge, indexed by edge number.
    bit [N-1:0] e_gnt  [MAXC];
    bit [N-1:0] e_ack  [MAXC];
    bit         rd_v   [MAXC];
    bit [3:0]   e_stb  [2][MAXC];
    bit [11:0]  e_din  [2][MAXC];
    bit         e_flag [2][MAXC];
    bit [11:0]  rd_val [2][MAXC];
    bit [11:0]  e_rd   [2][MAXC];
    int         m_ptr  = 0;
    int         m_free = 0;
    logic [11:0] m_reg [2] = '{12'h000, 12'h000};
    logic [11:0] m_rd  [2] = '{12'h000, 12'h000};

    always @(posedge CLK) begin : model
        int c, w, i;
        logic [1:0]  op;
        logic [11:0] d, nv;
        bit          lim;
        bit [3:0]    stb;
        c = cyc;
        if (c + 2 < MAXC) begin
            if (!RST_N) begin
                for (int j = 0; j < 3; j++) begin
                    e_gnt[c+j] = '0;
                    e_ack[c+j] = '0;
                    rd_v[c+j]  = 1'b0;
                    for (int k = 0; k < 2; k++) begin
                        e_stb[k][c+j]  = '0;
                        e_din[k][c+j]  = '0;
                        e_flag[k][c+j] = 1'b0;
                    end
                end
                m_ptr  = 0;
                m_free = c + 1;
                for (int k = 0; k < 2; k++) begin
                    m_rd[k]    = 12'h000;
                    e_rd[k][c] = 12'h000;
                end
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (rd_v[c]) m_rd[k] = rd_val[k][c];
                    e_rd[k][c] = m_rd[k];
                end
                if (c >= m_free && REQ != '0) begin
                    w = -1;
                    for (int s = 0; s < N; s++) begin
                        i = (m_ptr + s) % N;
                        if (w < 0 && REQ[i]) w = i;
                    end
                    op = OP[2*w +: 2];
                    d  = DATA[12*w +: 12];
                    e_gnt[c]   = N'(1) << w;
                    e_gnt[c+1] = N'(1) << w;
                    e_ack[c+2] = N'(1) << w;
                    rd_v[c+2]  = 1'b1;
                    for (int k = 0; k < 2; k++) begin
                        apply(op, d, m_reg[k], k == 1, nv, lim, stb);
                        e_stb[k][c+1]  = stb;
                        e_din[k][c+1]  = (op == LD) ? d : 12'h000;
                        e_flag[k][c+2] = lim;
                        rd_val[k][c+2] = nv;
                        m_reg[k]       = nv;
                    end
                    m_ptr  = (w + 1) % N;
                    m_free = c + 3;
                end
            end
        end
        cyc = c + 1;
    end

    always @(negedge CLK) begin : cmp
        int c;
        if (cyc > 0 && cyc <= MAXC - 3) begin
            c = cyc - 1;
            for (int k = 0; k < 2; k++) begin
                chk("GNT", k, c, 32'(gnt[k]), 32'(e_gnt[c]));
                chk("ACK", k, c, 32'(ack[k]), 32'(e_ack[c]));
                chk("RDATA", k, c, 32'(rdata[k]), 32'(e_rd[k][c]));
                chk("FLAG", k, c, 32'(flag[k]), 32'(e_flag[k][c]));
                chk("STROBES", k, c, 32'({clr[k], dec[k], inc[k], ld[k]}),
                    32'(e_stb[k][c]));
                chk("REG_DIN", k, c, 32'(din[k]), 32'(e_din[k][c]));
                chk("GNT_ONEHOT", k, c, 32'($onehot0(gnt[k])), 32'd1);
                chk("STB_ONEHOT", k, c,
                    32'($onehot0({clr[k], dec[k], inc[k], ld[k]})), 32'd1);
            end
        end
    end

    task automatic do_op(input int i, input logic [1:0] op, input logic [11:0] d,
                         input int hold, output int lat);
        int n;
        @(negedge CLK);
        OP[2*i +: 2]    = op;
        DATA[12*i +: 12] = d;
        REQ[i]          = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!gnt[0][i] && n < 20);
        chk("gnt_wait", i, cyc, 32'(gnt[0][i]), 32'd1);
        repeat (hold) @(negedge CLK);
        REQ[i] = 1'b0;
        lat = hold;
        while (!ack[0][i] && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        chk("ack_wait", i, cyc, 32'(ack[0][i]), 32'd1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int lat, n, w, last, s0, s1;
        int exp_w [4] = '{0, 1, 2, 0};

        repeat (3) @(negedge CLK);
        RST_N = 1'b1;

        // Single LOAD after reset.
        do_op(0, LD, 12'h5A5, 0, lat);
        chk("t1_latency", 0, cyc, lat, 2);
        chk("t1_rdata", 0, cyc, 32'(rdata[0]), 32'h5A5);
        chk("t1_flag", 0, cyc, 32'(flag[0]), 0);
        chk("t1_ld_count", 0, cyc, ld_cnt[0], 1);
        chk("t1_reg", 0, cyc, 32'(rq[0]), 32'h5A5);

        // Round robin: clear via requester 2 so the pointer returns to 0.
        do_op(2, CLR, 12'h000, 0, lat);
        @(negedge CLK);
        OP   = {INC, INC, INC};
        REQ  = '1;
        last = 0;
        for (int a = 0; a < 4; a++) begin
            n = 0;
            do begin
                @(negedge CLK);
                n++;
            end while (ack[0] == '0 && n < 20);
            chk("rr_ack_wait", a, cyc, 32'(ack[0] != '0), 1);
            w = -1;
            for (int j = 0; j < N; j++) if (ack[0][j]) w = j;
            chk("rr_winner", a, cyc, w, exp_w[a]);
            chk("rr_rdata", a, cyc, 32'(rdata[0]), a + 1);
            if (a > 0) chk("rr_gap", a, cyc, cyc - last, 3);
            last = cyc;
        end
        REQ = '0;
        repeat (2) @(negedge CLK);

        // Limits: dut0 wraps, dut1 saturates.
        do_op(0, LD, 12'hFFF, 0, lat);
        s0 = inc_cnt[0];
        s1 = inc_cnt[1];
        do_op(0, INC, 12'h000, 0, lat);
        chk("wrap_inc_rdata", 0, cyc, 32'(rdata[0]), 32'h000);
        chk("wrap_inc_flag", 0, cyc, 32'(flag[0]), 1);
        chk("wrap_inc_strobe", 0, cyc, inc_cnt[0] - s0, 1);
        chk("sat_inc_rdata", 1, cyc, 32'(rdata[1]), 32'hFFF);
        chk("sat_inc_flag", 1, cyc, 32'(flag[1]), 1);
        chk("sat_inc_nostrobe", 1, cyc, inc_cnt[1] - s1, 0);
        do_op(1, DEC, 12'h000, 0, lat);
        chk("wrap_dec_rdata", 0, cyc, 32'(rdata[0]), 32'hFFF);
        chk("wrap_dec_flag", 0, cyc, 32'(flag[0]), 1);
        chk("sat_dec_mid_rdata", 1, cyc, 32'(rdata[1]), 32'hFFE);
        chk("sat_dec_mid_flag", 1, cyc, 32'(flag[1]), 0);
        do_op(2, CLR, 12'h000, 0, lat);
        s1 = dec_cnt[1];
        do_op(0, DEC, 12'h000, 0, lat);
        chk("sat_dec_rdata", 1, cyc, 32'(rdata[1]), 32'h000);
        chk("sat_dec_flag", 1, cyc, 32'(flag[1]), 1);
        chk("sat_dec_nostrobe", 1, cyc, dec_cnt[1] - s1, 0);
        chk("wrap_dec2_rdata", 0, cyc, 32'(rdata[0]), 32'hFFF);

        // Withdrawal one cycle after grant.
        do_op(1, INC, 12'h000, 1, lat);
        chk("wd_latency", 1, cyc, lat, 2);
        chk("wd_rdata0", 0, cyc, 32'(rdata[0]), 32'h000);
        chk("wd_flag0", 0, cyc, 32'(flag[0]), 1);
        chk("wd_rdata1", 1, cyc, 32'(rdata[1]), 32'h001);
        chk("wd_flag1", 1, cyc, 32'(flag[1]), 0);

        // Reset asserted during RESP.
        @(negedge CLK);
        OP[1:0] = INC;
        REQ[0]  = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!gnt[0][0] && n < 20);
        chk("rst_gnt_wait", 0, cyc, 32'(gnt[0][0]), 1);
        REQ[0] = 1'b0;
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            chk("rst_ack", k, cyc, 32'(ack[k]), 0);
            chk("rst_gnt", k, cyc, 32'(gnt[k]), 0);
            chk("rst_rdata", k, cyc, 32'(rdata[k]), 0);
            chk("rst_flag", k, cyc, 32'(flag[k]), 0);
            chk("rst_strobes", k, cyc, 32'({clr[k], dec[k], inc[k], ld[k]}), 0);
            chk("rst_din", k, cyc, 32'(din[k]), 0);
        end
        chk("rst_reg_kept", 0, cyc, 32'(rq[0]), 32'h001);
        chk("rst_reg_kept", 1, cyc, 32'(rq[1]), 32'h002);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Random traffic; OP/DATA only change while a requester is idle.
        for (int t = 0; t < 1000; t++) begin
            @(negedge CLK);
            for (int i = 0; i < N; i++) begin
                if (!REQ[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        OP[2*i +: 2] = 2'($urandom_range(0, 3));
                        case ($urandom_range(0, 3))
                            0:       DATA[12*i +: 12] = 12'hFFF;
                            1:       DATA[12*i +: 12] = 12'h000;
                            default: DATA[12*i +: 12] = 12'($urandom);
                        endcase
                        REQ[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    REQ[i] = 1'b0;
                end
            end
        end
        REQ = '0;
        repeat (8) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
